// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared constants, types and helpers for the LED frame buffer.
//             Geometry is 4 columns of 8 row bits plus a 3-bit brightness.
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

  localparam int LED_COLS  = 4;
  localparam int LED_ROWS  = 8;
  localparam int LED_PWM_W = 3;

  // Column index, 0 selects leds1 ... 3 selects leds4
  typedef logic [1:0]          col_t;
  typedef logic [LED_ROWS-1:0] col_data_t;
  typedef logic [LED_PWM_W-1:0] pwm_t;

  // Commit handshake state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_t;

  // Bitwise masked merge: only bits with mask=1 take the new data
  function automatic col_data_t merge_bits(input col_data_t old_bits,
                                           input col_data_t new_bits,
                                           input col_data_t mask);
    return (old_bits & ~mask) | (new_bits & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tick_gen
//  Purpose  : Free-running modulo-FRAME_DIV counter producing a registered
//             one-cycle frame tick whenever the count sits at FRAME_DIV-1.
//  Ports    : clk12MHz   - system clock
//             rst_n      - asynchronous active-low reset
//             frame_tick - one-cycle pulse every FRAME_DIV cycles
//  Revision : 1.0  initial release
// ============================================================================
module frame_tick_gen #(
  parameter int FRAME_DIV = 48000
) (
  input  logic clk12MHz,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int            CW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == c_last) ? '0 : cnt_q + CW'(1);
    // Tick flop mirrors "count == last" so it stays aligned with the counter
    tick_d = (cnt_d == c_last);
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/led_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : led_frame_buffer
//  Purpose  : Double-buffered 4x8 LED frame store. Producers edit the back
//             buffer; a commit copies it to the front buffer on the next
//             frame tick so the display never shows a partial frame.
//  Ports    : clk12MHz, rst_n            - clock, async active-low reset
//             wr_valid/wr_ready          - write handshake
//             wr_col, wr_data, wr_mask   - masked column write
//             clear, commit              - back-buffer clear, swap request
//             pwm_in                     - brightness for the back buffer
//             commit_busy, frame_tick    - status
//             leds1..leds4, leds_pwm     - registered front buffer
//  Revision : 1.0  initial release
// ============================================================================
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int FRAME_DIV = 48000
) (
  input  logic                 clk12MHz,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [1:0]           wr_col,
  input  logic [LED_ROWS-1:0]  wr_data,
  input  logic [LED_ROWS-1:0]  wr_mask,
  input  logic                 clear,
  input  logic                 commit,
  input  logic [LED_PWM_W-1:0] pwm_in,
  output logic                 commit_busy,
  output logic                 frame_tick,
  output logic [LED_ROWS-1:0]  leds1,
  output logic [LED_ROWS-1:0]  leds2,
  output logic [LED_ROWS-1:0]  leds3,
  output logic [LED_ROWS-1:0]  leds4,
  output logic [LED_PWM_W-1:0] leds_pwm
);

  state_t state_q, state_d;

  logic [LED_COLS-1:0][LED_ROWS-1:0] back_q,  back_d;
  logic [LED_COLS-1:0][LED_ROWS-1:0] front_q, front_d;
  pwm_t                              back_pwm_q,  back_pwm_d;
  pwm_t                              front_pwm_q, front_pwm_d;

  logic w_swap_en;
  col_t w_col;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV)
  ) u_tick (
    .clk12MHz   (clk12MHz),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign w_col     = wr_col;
  assign w_swap_en = (state_q == PENDING) && frame_tick;

  // ---- FSM: state register ----
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (frame_tick) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs (pure state decode, no input paths) ----
  always_comb begin
    wr_ready    = (state_q == IDLE);
    commit_busy = (state_q != IDLE);
  end

  // ---- Buffer datapath ----
  always_comb begin
    back_d      = back_q;
    back_pwm_d  = back_pwm_q;
    front_d     = front_q;
    front_pwm_d = front_pwm_q;

    if (state_q == IDLE) begin
      // Clear lands first so a same-cycle write survives on top of zeros
      if (clear) begin
        back_d = '0;
      end
      if (wr_valid) begin
        back_d[w_col] = merge_bits(back_d[w_col], wr_data, wr_mask);
      end
      back_pwm_d = pwm_in;
    end

    // Back buffer is left intact so later edits build on this frame
    if (w_swap_en) begin
      front_d     = back_q;
      front_pwm_d = back_pwm_q;
    end
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      back_q      <= '0;
      back_pwm_q  <= '0;
      front_q     <= '0;
      front_pwm_q <= '0;
    end else begin
      back_q      <= back_d;
      back_pwm_q  <= back_pwm_d;
      front_q     <= front_d;
      front_pwm_q <= front_pwm_d;
    end
  end

  assign leds1    = front_q[0];
  assign leds2    = front_q[1];
  assign leds3    = front_q[2];
  assign leds4    = front_q[3];
  assign leds_pwm = front_pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_frame_buffer
//  Purpose  : Self-checking bench for led_frame_buffer with FRAME_DIV=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_frame_buffer;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_col = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] wr_mask = 8'h00;
  logic       clear = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] pwm_in = 3'd0;
  logic       commit_busy;
  logic       frame_tick;
  logic [7:0] leds1, leds2, leds3, leds4;
  logic [2:0] leds_pwm;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  led_frame_buffer #(.FRAME_DIV(FD)) dut (
    .clk12MHz    (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .clear       (clear),
    .commit      (commit),
    .pwm_in      (pwm_in),
    .commit_busy (commit_busy),
    .frame_tick  (frame_tick),
    .leds1       (leds1),
    .leds2       (leds2),
    .leds3       (leds3),
    .leds4       (leds4),
    .leds_pwm    (leds_pwm)
  );

  // ---------------- Behavioural model ----------------
  // m_age counts cycles since reset release modulo FD; a tick is the cycle
  // where that count is FD-1. m_pend = commit waiting, m_swap = swap cycle.
  logic [7:0] m_back  [4];
  logic [7:0] m_front [4];
  logic [2:0] m_bpwm, m_fpwm;
  bit         m_pend, m_swap;
  int         m_age;

  function automatic logic [7:0] back_next(input int c);
    logic [7:0] v;
    v = clear ? 8'h00 : m_back[c];
    if (wr_valid && int'(wr_col) == c)
      v = (v & ~wr_mask) | (wr_data & wr_mask);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_back[c]  <= 8'h00;
        m_front[c] <= 8'h00;
      end
      m_bpwm <= 3'd0;
      m_fpwm <= 3'd0;
      m_pend <= 1'b0;
      m_swap <= 1'b0;
      m_age  <= 0;
    end else begin
      m_age <= (m_age + 1) % FD;
      if (m_swap) begin
        m_swap <= 1'b0;
      end else if (m_pend) begin
        if (m_age == FD - 1) begin
          for (int c = 0; c < 4; c++) m_front[c] <= m_back[c];
          m_fpwm <= m_bpwm;
          m_pend <= 1'b0;
          m_swap <= 1'b1;
        end
      end else begin
        for (int c = 0; c < 4; c++) m_back[c] <= back_next(c);
        m_bpwm <= pwm_in;
        if (commit) m_pend <= 1'b1;
      end
    end
  end

  // ---------------- Checking ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: wait for the falling edge, then compare every output to the model
  task automatic cycle();
    @(negedge clk);
    cyc++;
    chk("leds1",       leds1, m_front[0]);
    chk("leds2",       leds2, m_front[1]);
    chk("leds3",       leds3, m_front[2]);
    chk("leds4",       leds4, m_front[3]);
    chk("leds_pwm",    8'(leds_pwm), 8'(m_fpwm));
    chk("wr_ready",    8'(wr_ready), 8'(!(m_pend || m_swap)));
    chk("commit_busy", 8'(commit_busy), 8'(m_pend || m_swap));
    chk("frame_tick",  8'(frame_tick), 8'(m_age == FD - 1));
  endtask

  task automatic write(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m);
    wr_valid = 1'b1; wr_col = c; wr_data = d; wr_mask = m;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!commit_busy) return;
      cycle();
    end
    tests++;
    fails++;
    $display("FAIL wait_idle: commit_busy still %b after 20 cycles", commit_busy);
  endtask

  initial begin
    pwm_in = 3'd5;

    // Reset state
    repeat (3) cycle();
    chk("rst_leds1",    leds1, 8'h00);
    chk("rst_leds4",    leds4, 8'h00);
    chk("rst_pwm",      8'(leds_pwm), 8'h00);
    chk("rst_wr_ready", 8'(wr_ready), 8'h01);
    chk("rst_tick",     8'(frame_tick), 8'h00);

    // Tick cadence after release: pulses at cycles 3, 7, 11
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("tick_cycle", 8'(frame_tick), 8'((cyc == 3) || (cyc == 7) || (cyc == 11)));
    end

    // Plain write + commit
    write(2'd2, 8'hA5, 8'hFF);
    chk("not_yet_visible", leds3, 8'h00);
    do_commit();
    wait_idle();
    chk("wc_leds3", leds3, 8'hA5);
    chk("wc_leds1", leds1, 8'h00);
    chk("wc_pwm",   8'(leds_pwm), 8'h05);

    // Masked merge: F0 merged with 0F under mask 3C -> CC
    pwm_in = 3'd2;
    write(2'd0, 8'hF0, 8'hFF);
    write(2'd0, 8'h0F, 8'h3C);
    do_commit();
    wait_idle();
    chk("merge_leds1", leds1, 8'hCC);
    chk("merge_leds3", leds3, 8'hA5);
    chk("merge_pwm",   8'(leds_pwm), 8'h02);

    // Stall: write held while a commit is outstanding
    do_commit();
    chk("stall_ready", 8'(wr_ready), 8'h00);
    wr_valid = 1'b1; wr_col = 2'd1; wr_data = 8'h55; wr_mask = 8'hFF;
    begin : stall_loop
      for (int i = 0; i < 20; i++) begin
        if (wr_ready) begin
          cycle();
          disable stall_loop;
        end
        cycle();
      end
      tests++;
      fails++;
      $display("FAIL stall: wr_ready never returned, got %b expected 1", wr_ready);
    end
    wr_valid = 1'b0;
    repeat (FD + 1) cycle();
    chk("stall_old_leds2", leds2, 8'h00);
    do_commit();
    wait_idle();
    chk("stall_new_leds2", leds2, 8'h55);

    // Clear + write together, then a second commit and clear while pending
    clear = 1'b1;
    write(2'd3, 8'h81, 8'hFF);
    clear = 1'b0;
    do_commit();
    clear = 1'b1;
    do_commit();
    clear = 1'b0;
    wait_idle();
    chk("sim_leds4", leds4, 8'h81);
    chk("sim_leds1", leds1, 8'h00);
    chk("sim_leds2", leds2, 8'h00);
    chk("sim_leds3", leds3, 8'h00);
    repeat (FD + 2) cycle();
    chk("single_swap_busy", 8'(commit_busy), 8'h00);

    // Reset while a commit is pending
    write(2'd0, 8'hFF, 8'hFF);
    do_commit();
    rst_n = 1'b0;
    cycle();
    chk("midrst_leds4", leds4, 8'h00);
    chk("midrst_busy",  8'(commit_busy), 8'h00);
    rst_n = 1'b1;
    repeat (2 * FD + 1) cycle();
    chk("postrst_leds1", leds1, 8'h00);
    chk("postrst_leds4", leds4, 8'h00);
    chk("postrst_busy",  8'(commit_busy), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
